// File: rtl/lane_hit_judge_if.sv
// Signal bundle between the note-row shifter, the lane keys and the score display.
// The master drives the judgement request and key levels; the slave returns the verdict and counters.
interface lane_hit_judge_if #(
  parameter int LANES    = 4,
  parameter int SCORE_W  = 16,
  parameter int STREAK_W = 8
) ();
  logic                check_go;
  logic [LANES-1:0]    row_note;
  logic [LANES-1:0]    key_n;
  logic                check_done;
  logic                hit;
  logic                miss;
  logic [SCORE_W-1:0]  score;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] max_streak;

  modport master (
    output check_go, row_note, key_n,
    input  check_done, hit, miss, score, streak, max_streak
  );

  modport slave (
    input  check_go, row_note, key_n,
    output check_done, hit, miss, score, streak, max_streak
  );
endinterface

// File: rtl/lane_hit_judge.sv
// Judges one strike-row note or chord against new key presses inside a timing window.
// It also keeps the saturating score, the current streak and the best streak since reset.
module lane_hit_judge #(
  parameter int LANES    = 4,
  parameter int WINDOW   = 8,
  parameter int SCORE_W  = 16,
  parameter int STREAK_W = 8
) (
  input logic              clk,
  input logic              reset,
  lane_hit_judge_if.slave  lane_io
);

  localparam int TW = $clog2(WINDOW);

  typedef enum logic [1:0] {IDLE, JUDGE, DONE} state_e;

  state_e              state_q, state_d;
  logic [LANES-1:0]    keyPrev_q;
  logic [LANES-1:0]    noteMask_q, noteMask_d;
  logic [LANES-1:0]    got_q, got_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                checkDone_q, checkDone_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [STREAK_W-1:0] maxStreak_q, maxStreak_d;

  logic [LANES-1:0]    press;
  logic [LANES-1:0]    pressHit;
  logic                wrongKey;
  logic                allGot;
  logic [SCORE_W:0]    popCnt;
  logic [SCORE_W:0]    scoreSum;
  logic [STREAK_W-1:0] streakInc;

  // keyPrev_q follows the keys even in reset, so a key held through reset is never seen as a press
  always_ff @(posedge clk) begin
    keyPrev_q <= lane_io.key_n;
    if (reset) begin
      state_q     <= IDLE;
      noteMask_q  <= '0;
      got_q       <= '0;
      timer_q     <= '0;
      checkDone_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      streak_q    <= '0;
      maxStreak_q <= '0;
    end else begin
      state_q     <= state_d;
      noteMask_q  <= noteMask_d;
      got_q       <= got_d;
      timer_q     <= timer_d;
      checkDone_q <= checkDone_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      streak_q    <= streak_d;
      maxStreak_q <= maxStreak_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    noteMask_d  = noteMask_q;
    got_d       = got_q;
    timer_d     = timer_q;
    checkDone_d = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    score_d     = score_q;
    streak_d    = streak_q;
    maxStreak_d = maxStreak_q;

    press    = keyPrev_q & ~lane_io.key_n;
    pressHit = press & noteMask_q;
    wrongKey = |(press & ~noteMask_q);
    allGot   = ((got_q | pressHit) == noteMask_q);

    popCnt = '0;
    for (int i = 0; i < LANES; i++) begin
      popCnt = popCnt + (SCORE_W+1)'(noteMask_q[i]);
    end
    scoreSum  = {1'b0, score_q} + popCnt;
    streakInc = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);

    // Verdict flags are registered alongside the DONE transition so they line up with check_done
    case (state_q)
      IDLE: begin
        if (lane_io.check_go) begin
          noteMask_d = lane_io.row_note;
          got_d      = '0;
          timer_d    = '0;
          if (lane_io.row_note == '0) begin
            state_d     = DONE;
            checkDone_d = 1'b1;
          end else begin
            state_d = JUDGE;
          end
        end
      end
      JUDGE: begin
        if (wrongKey) begin
          state_d     = DONE;
          checkDone_d = 1'b1;
          miss_d      = 1'b1;
          streak_d    = '0;
        end else if (allGot) begin
          state_d     = DONE;
          checkDone_d = 1'b1;
          hit_d       = 1'b1;
          score_d     = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
          streak_d    = streakInc;
          if (streakInc > maxStreak_q) begin
            maxStreak_d = streakInc;
          end
        end else if (timer_q == TW'(WINDOW-1)) begin
          state_d     = DONE;
          checkDone_d = 1'b1;
          miss_d      = 1'b1;
          streak_d    = '0;
        end else begin
          got_d   = got_q | pressHit;
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lane_io.check_done = checkDone_q;
  assign lane_io.hit        = hit_q;
  assign lane_io.miss       = miss_q;
  assign lane_io.score      = score_q;
  assign lane_io.streak     = streak_q;
  assign lane_io.max_streak = maxStreak_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Bench for lane_hit_judge: directed scenarios plus randomized judgements against a per-note reference model.
// Narrow score and streak widths make both saturation limits reachable.
module tb_lane_hit_judge;

  localparam int LANES      = 4;
  localparam int WINDOW     = 8;
  localparam int SCORE_W    = 5;
  localparam int STREAK_W   = 2;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
  localparam int STREAK_MAX = (1 << STREAK_W) - 1;

  typedef logic [LANES-1:0] lane_t;
  typedef lane_t seq_t [0:WINDOW+1];

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   mScore = 0;
  int   mStreak = 0;
  int   mMax = 0;

  always #5 clk = ~clk;

  lane_hit_judge_if #(.LANES(LANES), .SCORE_W(SCORE_W), .STREAK_W(STREAK_W)) bus ();

  lane_hit_judge #(
    .LANES(LANES), .WINDOW(WINDOW), .SCORE_W(SCORE_W), .STREAK_W(STREAK_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lane_io(bus)
  );

  // ks[0] is the key level in the check_go cycle, ks[j] the level j cycles later.
  // verdict: 0 = none, 1 = hit, 2 = miss; doneAt is cycles after check_go.
  function automatic void predict(input lane_t note, input seq_t ks, output int doneAt, output int verdict);
    lane_t seen;
    lane_t fell;
    seen = '0;
    if (note == '0) begin
      doneAt = 1; verdict = 0; return;
    end
    for (int k = 1; k <= WINDOW; k++) begin
      fell = ks[k-1] & ~ks[k];
      if ((fell & ~note) != '0) begin
        doneAt = k + 1; verdict = 2; return;
      end
      seen = seen | (fell & note);
      if (seen == note) begin
        doneAt = k + 1; verdict = 1; return;
      end
    end
    doneAt = WINDOW + 1; verdict = 2;
  endfunction

  function automatic seq_t mkSeq(input lane_t base, input lane_t fall1, input int c1, input lane_t fall2, input int c2);
    seq_t s;
    for (int j = 0; j <= WINDOW + 1; j++) begin
      s[j] = base;
      if (j >= c1) s[j] = s[j] & ~fall1;
      if (j >= c2) s[j] = s[j] & ~fall2;
    end
    return s;
  endfunction

  task automatic checkCounters(input string name, input int expS, input int expSt, input int expM);
    vectors++;
    if (bus.score !== SCORE_W'(expS) || bus.streak !== STREAK_W'(expSt) || bus.max_streak !== STREAK_W'(expM)) begin
      miscompares++;
      $display("[TB] FAIL %s counters: got score=%0d streak=%0d max=%0d, expected score=%0d streak=%0d max=%0d",
               name, bus.score, bus.streak, bus.max_streak, expS, expSt, expM);
    end
  endtask

  task automatic judge(input string name, input lane_t note, input seq_t ks, input bit noisy);
    int d, v, oldS, oldSt, oldM;
    logic [2:0] expFlags;
    predict(note, ks, d, v);
    oldS = mScore; oldSt = mStreak; oldM = mMax;
    if (v == 1) begin
      mScore  = (mScore + $countones(note) > SCORE_MAX) ? SCORE_MAX : mScore + $countones(note);
      mStreak = (mStreak + 1 > STREAK_MAX) ? STREAK_MAX : mStreak + 1;
      if (mStreak > mMax) mMax = mStreak;
    end else if (v == 2) begin
      mStreak = 0;
    end
    @(negedge clk);
    bus.check_go = 1'b1;
    bus.row_note = note;
    bus.key_n    = ks[0];
    for (int j = 1; j <= d; j++) begin
      @(negedge clk);
      expFlags = (j == d) ? {1'b1, v == 1, v == 2} : 3'b000;
      vectors++;
      if ({bus.check_done, bus.hit, bus.miss} !== expFlags) begin
        miscompares++;
        $display("[TB] FAIL %s flags at t+%0d: got done/hit/miss=%b expected %b",
                 name, j, {bus.check_done, bus.hit, bus.miss}, expFlags);
      end
      if (j == d) checkCounters(name, mScore, mStreak, mMax);
      else        checkCounters(name, oldS, oldSt, oldM);
      bus.check_go = (noisy && j < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.row_note = lane_t'($urandom);
      bus.key_n    = ks[j];
    end
  endtask

  task automatic checkAllZero(input string name);
    vectors++;
    if ({bus.check_done, bus.hit, bus.miss} !== 3'b000 || bus.score !== '0 || bus.streak !== '0 || bus.max_streak !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s: got done/hit/miss=%b score=%0d streak=%0d max=%0d, expected all zero",
               name, {bus.check_done, bus.hit, bus.miss}, bus.score, bus.streak, bus.max_streak);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.check_go = 1'b0;
    bus.row_note = '0;
    bus.key_n    = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.check_go = 1'($urandom_range(0, 1));
      bus.row_note = lane_t'($urandom);
      checkAllZero("reset_state");
    end
    bus.check_go = 1'b0;
    bus.key_n    = '1;
    reset        = 1'b0;
    mScore = 0; mStreak = 0; mMax = 0;
  endtask

  task automatic test_single_lane();
    judge("single_hit", 4'b0100, mkSeq('1, 4'b0100, 3, '0, 99), 1'b0);
    judge("timeout", 4'b0001, mkSeq('1, '0, 99, '0, 99), 1'b0);
  endtask

  task automatic test_chord();
    judge("chord_hit", 4'b1001, mkSeq('1, 4'b0001, 2, 4'b1000, 5), 1'b0);
    judge("chord_wrong", 4'b1001, mkSeq('1, 4'b0010, 3, '0, 99), 1'b0);
  endtask

  task automatic test_conflict();
    judge("same_cycle_wrong", 4'b0010, mkSeq('1, 4'b0110, 1, '0, 99), 1'b0);
    judge("held_before_go", 4'b0010, mkSeq(4'b1101, '0, 99, '0, 99), 1'b0);
  endtask

  task automatic test_saturation();
    lane_t n;
    for (int i = 0; i < 5; i++) begin
      n = lane_t'($urandom_range(1, (1 << LANES) - 1));
      judge("sat_hit", n, mkSeq('1, n, 1, '0, 99), 1'b0);
    end
    judge("sat_miss", 4'b0001, mkSeq('1, 4'b0010, 1, '0, 99), 1'b0);
    judge("empty_row", 4'b0000, mkSeq('1, '0, 99, '0, 99), 1'b0);
  endtask

  task automatic test_reset_mid_judge();
    @(negedge clk);
    bus.check_go = 1'b1; bus.row_note = 4'b0001; bus.key_n = '1;
    @(negedge clk);
    bus.check_go = 1'b1; bus.row_note = 4'b0010;
    @(negedge clk);
    vectors++;
    if (bus.check_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_judge_done: got %b expected 0", bus.check_done);
    end
    bus.check_go = 1'b0; reset = 1'b1; bus.key_n = 4'b1110;
    @(negedge clk);
    checkAllZero("reset_mid_judge");
    reset = 1'b0;
    mScore = 0; mStreak = 0; mMax = 0;
    @(negedge clk);
    checkAllZero("after_reset_idle");
    judge("held_through_reset", 4'b0001, mkSeq(4'b1110, '0, 99, '0, 99), 1'b1);
  endtask

  task automatic test_back_to_back();
    seq_t  ks;
    lane_t n;
    for (int r = 0; r < 60; r++) begin
      n = ($urandom_range(0, 7) == 0) ? '0 : lane_t'($urandom);
      ks[0] = ~(lane_t'($urandom) & lane_t'($urandom));
      for (int j = 1; j <= WINDOW + 1; j++) begin
        ks[j] = ks[j-1] ^ (lane_t'($urandom) & lane_t'($urandom) & lane_t'($urandom));
      end
      judge("random", n, ks, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_chord();
    test_conflict();
    test_saturation();
    test_reset_mid_judge();
    test_back_to_back();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_hit_judge.md
# lane_hit_judge

Parametrised note-judgement block for the rhythm-game datapath: for each strike-row note (single lane or chord) it watches the active-low lane keys for new presses inside a configurable timing window, then reports hit or miss with a one-cycle done pulse. It also keeps the running score, current streak and best streak. It sits between the note-row shifter, which issues `check_go` with the strike-row lane mask, and the score/HEX display logic.

## Interface
- `LANES`, default 4: number of note lanes/keys (≥1).
- `WINDOW`, default 8: judgement window in clock cycles (≥2).
- `SCORE_W`, default 16: score counter width.
- `STREAK_W`, default 8: streak counter width.

- `clk` in 1: the single system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `check_go` in 1: start a judgement; sampled only in IDLE.
- `row_note` in LANES: strike-row note mask; bit i set means a note in lane i; multiple bits form a chord.
- `key_n` in LANES: lane keys, active-low, already synchronised and debounced upstream.
- `check_done` out 1: one-cycle pulse when the judgement completes.
- `hit` out 1: valid only while `check_done`=1.
- `miss` out 1: valid only while `check_done`=1.
- `score` out SCORE_W: accumulated score.
- `streak` out STREAK_W: consecutive hits.
- `max_streak` out STREAK_W: best streak since reset.

## Operation
- Press detection: `press = key_prev & ~key_n`, a falling edge of `key_n`. `key_prev` is registered every cycle. During reset `key_prev` loads `key_n`, so a key held through reset is not a press. A key already held at `check_go` never counts.
- Registers: `note_mask` (LANES), `got` (LANES), `timer` ($clog2(WINDOW)), and state.
- **IDLE**
  - On `check_go`=1: `note_mask<=row_note`, `got<=0`, `timer<=0`.
  - If `row_note`==0, go to DONE with verdict none. Otherwise go to JUDGE.
- **JUDGE**, evaluated each cycle from the current `press`:
  - wrong = |(press & ~note_mask).
  - all = ((got | (press & note_mask)) == note_mask).
  - If wrong: verdict miss, go to DONE. Wrong key has priority over completion in the same cycle.
  - Else if all: verdict hit, go to DONE.
  - Else if `timer`==WINDOW-1: verdict miss (timeout), go to DONE.
  - Else: `got <= got | (press & note_mask)`, `timer <= timer+1`.
  - Chord lanes may be pressed in any cycles within the window. A second press of an already-got lane has no effect.
- **DONE**: lasts one cycle.
  - `check_done`=1; `hit`/`miss` reflect the verdict. Verdict none gives `hit`=`miss`=0.
  - Always returns to IDLE.
- Score and streak update on entry to DONE, so new values are visible in the DONE cycle.
  - Hit:
    - `score += popcount(note_mask)`, saturating at 2^SCORE_W-1.
    - `streak += 1`, saturating at 2^STREAK_W-1.
    - `max_streak <= max(max_streak, new streak)`.
  - Miss: `streak <= 0`; `score` unchanged.
  - None: no change.
- `check_go` in JUDGE or DONE is ignored; it is not queued.
- Reset at any time, including mid-JUDGE: state IDLE and all counters cleared; the in-flight judgement is abandoned with no `check_done`.

## Timing
- Reset values: `check_done`=0, `hit`=0, `miss`=0, `score`=0, `streak`=0, `max_streak`=0; `note_mask`=0, `got`=0, `timer`=0; state IDLE.
- `check_go` is sampled at cycle t. JUDGE occupies cycles t+1 … t+WINDOW at most.
- A decision made in cycle k produces `check_done` in cycle k+1.
- Empty row: `check_done` at t+1.
- Fastest hit (press at t+1): `check_done` at t+2.
- Timeout: `check_done` at t+WINDOW+1.
- Earliest next accepted `check_go` is the cycle after DONE.
- All outputs are registered; no combinational path from `key_n` or `check_go` to any output.

## Test plan
- Reset, then LANES=4, WINDOW=8: `check_go` with `row_note`=0100; `key_n` bit2 falls 3 cycles later. Required: `check_done`, `hit`=1 at t+4; `score`=1, `streak`=1, `max_streak`=1.
- `row_note`=0001, no press. Required: `check_done`, `miss`=1 at t+9; `streak`=0; `score` unchanged.
- Chord `row_note`=1001: bit0 falls at t+2, bit3 falls at t+5. Required: hit at t+6; `score` increases by 2. Same chord with bit1 falling at t+3: miss at t+4.
- Same-cycle conflict: `row_note`=0010, bits 1 and 2 fall together at t+1. Required: miss at t+2. Separately, bit1 held low before `check_go` and never released: timeout miss at t+9.
- Saturation with STREAK_W=2 and 5 consecutive hits: `streak` is 3 after hit 3 and stays 3; one miss makes `streak`=0 while `max_streak` stays 3. Empty row: `check_done` at t+1, `hit`=`miss`=0, counters unchanged.
- Reset asserted mid-JUDGE: no `check_done`; all outputs 0 the next cycle. A key held through reset does not produce a hit on the next `check_go`. A `check_go` pulse during JUDGE is ignored.
